// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for the 7-segment scan bus decoder.
// Segment codes are active-low, with bit7 as the dot and bits[6:0] as g..a.
package seg_scan_decoder_pkg;

  localparam logic [7:0] NUMBER_0 = 8'hC0;
  localparam logic [7:0] NUMBER_1 = 8'hF9;
  localparam logic [7:0] NUMBER_2 = 8'hA4;
  localparam logic [7:0] NUMBER_3 = 8'hB0;
  localparam logic [7:0] NUMBER_4 = 8'h99;
  localparam logic [7:0] NUMBER_5 = 8'h92;
  localparam logic [7:0] NUMBER_6 = 8'h82;
  localparam logic [7:0] NUMBER_7 = 8'hF8;
  localparam logic [7:0] NUMBER_8 = 8'h80;
  localparam logic [7:0] NUMBER_9 = 8'h90;

  localparam logic [5:0] DIGIT_BLOCK_1 = 6'b111110;
  localparam logic [5:0] DIGIT_BLOCK_2 = 6'b111101;
  localparam logic [5:0] DIGIT_BLOCK_3 = 6'b111011;
  localparam logic [5:0] DIGIT_BLOCK_4 = 6'b110111;
  localparam logic [5:0] DIGIT_BLOCK_5 = 6'b101111;
  localparam logic [5:0] DIGIT_BLOCK_6 = 6'b011111;
  localparam logic [5:0] DIGIT_BLANK   = 6'b111111;

  localparam int SLOT_SEC_ONES = 0;
  localparam int SLOT_SEC_TENS = 1;
  localparam int SLOT_MIN_ONES = 2;
  localparam int SLOT_MIN_TENS = 3;
  localparam int SLOT_HR_ONES  = 4;
  localparam int SLOT_HR_TENS  = 5;

  // Slots whose dot must be lit (the HH.MM.SS separators).
  localparam logic [5:0] DOT_REQUIRED = 6'b010100;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} scan_state_t;

  function automatic logic [5:0] times_ten(input logic [3:0] t);
    logic [5:0] w;
    w = {2'b00, t};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_digit_decode.sv
// Combinational decode of one active-low segment byte back to a BCD digit.
module seg7_digit_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] digit,
  output logic       pattern_ok,
  output logic       dot_lit
);

  always_comb begin
    digit      = 4'd0;
    pattern_ok = 1'b1;
    dot_lit    = ~seg[7];
    case ({1'b1, seg[6:0]})
      NUMBER_0: digit = 4'd0;
      NUMBER_1: digit = 4'd1;
      NUMBER_2: digit = 4'd2;
      NUMBER_3: digit = 4'd3;
      NUMBER_4: digit = 4'd4;
      NUMBER_5: digit = 4'd5;
      NUMBER_6: digit = 4'd6;
      NUMBER_7: digit = 4'd7;
      NUMBER_8: digit = 4'd8;
      NUMBER_9: digit = 4'd9;
      default:  pattern_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors the multiplexed 6-digit display bus and reassembles HH.MM.SS.
// A digit is captured only after its select/segment pair has been stable for SETTLE_CYCLES.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_mod,
  input  logic [5:0] digit_block,
  input  logic [7:0] number,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       time_valid,
  output logic       frame_err,
  output logic       locked
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [5:0]      db_meta_reg, db_sync_reg, db_prev_reg, smp_db_reg;
  logic [7:0]      num_meta_reg, num_sync_reg, num_prev_reg, smp_num_reg;
  logic [3:0]      count_reg;
  scan_state_t     state_reg;
  logic [3:0]      digit_reg [6];
  logic [5:0]      mask_reg;
  logic            bad_reg;
  logic [WD_W-1:0] wd_reg;

  logic            change;
  logic [3:0]      dec_digit;
  logic            dec_ok, dec_dot;
  logic [2:0]      slot_idx;
  logic            is_blank, one_hot, frame_good;
  logic [5:0]      mask_next;
  logic            bad_next;
  logic [3:0]      cur [6];
  logic [5:0]      sec_val, min_val, hr_val;

  assign change = {db_sync_reg, num_sync_reg} != {db_prev_reg, num_prev_reg};

  seg7_digit_decode u_decode (
    .seg        (smp_num_reg),
    .digit      (dec_digit),
    .pattern_ok (dec_ok),
    .dot_lit    (dec_dot)
  );

  // Frame state as it would look after absorbing the sampled digit.
  always_comb begin
    slot_idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (!smp_db_reg[i]) slot_idx = 3'(i);
    is_blank  = (smp_db_reg == DIGIT_BLANK);
    one_hot   = $onehot(~smp_db_reg);
    mask_next = mask_reg | ~smp_db_reg;
    bad_next  = bad_reg | ~dec_ok | (dec_dot != DOT_REQUIRED[slot_idx]);
    for (int i = 0; i < 6; i++)
      cur[i] = (3'(i) == slot_idx) ? dec_digit : digit_reg[i];
    sec_val = times_ten(cur[SLOT_SEC_TENS]) + {2'b00, cur[SLOT_SEC_ONES]};
    min_val = times_ten(cur[SLOT_MIN_TENS]) + {2'b00, cur[SLOT_MIN_ONES]};
    hr_val  = times_ten(cur[SLOT_HR_TENS])  + {2'b00, cur[SLOT_HR_ONES]};
    frame_good = !bad_next
              && (cur[SLOT_SEC_TENS] <= 4'd5) && (sec_val < 6'd60)
              && (cur[SLOT_MIN_TENS] <= 4'd5) && (min_val < 6'd60)
              && (cur[SLOT_HR_TENS]  <= 4'd2) && (hr_val  < 6'd24);
  end

  always_ff @(posedge clk or negedge reset_mod) begin
    if (!reset_mod) begin
      db_meta_reg  <= DIGIT_BLANK;
      db_sync_reg  <= DIGIT_BLANK;
      db_prev_reg  <= DIGIT_BLANK;
      smp_db_reg   <= DIGIT_BLANK;
      num_meta_reg <= 8'hFF;
      num_sync_reg <= 8'hFF;
      num_prev_reg <= 8'hFF;
      smp_num_reg  <= 8'hFF;
      count_reg    <= 4'd0;
      state_reg    <= IDLE;
      for (int i = 0; i < 6; i++) digit_reg[i] <= 4'd0;
      mask_reg     <= 6'd0;
      bad_reg      <= 1'b0;
      wd_reg       <= '0;
      hours        <= 6'd0;
      minutes      <= 6'd0;
      seconds      <= 6'd0;
      time_valid   <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      time_valid   <= 1'b0;
      frame_err    <= 1'b0;
      db_meta_reg  <= digit_block;
      db_sync_reg  <= db_meta_reg;
      db_prev_reg  <= db_sync_reg;
      num_meta_reg <= number;
      num_sync_reg <= num_meta_reg;
      num_prev_reg <= num_sync_reg;

      if (state_reg == CAPTURE)
        wd_reg <= '0;
      else if (wd_reg != WD_W'(TIMEOUT_CYCLES))
        wd_reg <= wd_reg + 1'b1;
      if (state_reg != CAPTURE && wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
        locked   <= 1'b0;
        mask_reg <= 6'd0;
        bad_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE, HOLD: begin
          if (change) begin
            state_reg <= SETTLE;
            count_reg <= 4'd1;
          end
        end
        SETTLE: begin
          if (change) begin
            count_reg <= 4'd1;
          end else if (count_reg >= 4'(SETTLE_CYCLES)) begin
            state_reg   <= CAPTURE;
            smp_db_reg  <= db_sync_reg;
            smp_num_reg <= num_sync_reg;
          end else begin
            count_reg <= count_reg + 4'd1;
            if ({1'b0, count_reg} + 5'd1 == 5'(SETTLE_CYCLES)) begin
              state_reg   <= CAPTURE;
              smp_db_reg  <= db_sync_reg;
              smp_num_reg <= num_sync_reg;
            end
          end
        end
        CAPTURE: begin
          if (change) begin
            state_reg <= SETTLE;
            count_reg <= 4'd1;
          end else begin
            state_reg <= HOLD;
          end
          if (is_blank) begin
            mask_reg <= 6'd0;
            bad_reg  <= 1'b0;
            locked   <= 1'b0;
          end else if (!one_hot) begin
            frame_err <= 1'b1;
            mask_reg  <= 6'd0;
            bad_reg   <= 1'b0;
          end else begin
            digit_reg[slot_idx] <= dec_digit;
            if (mask_next == 6'h3F) begin
              mask_reg <= 6'd0;
              bad_reg  <= 1'b0;
              if (frame_good) begin
                hours      <= hr_val;
                minutes    <= min_val;
                seconds    <= sec_val;
                time_valid <= 1'b1;
                locked     <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              mask_reg <= mask_next;
              bad_reg  <= bad_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 6-digit 7-segment display bus that the clock/timer blocks drive.
- Samples the active-low digit select (digit_block) and the segment byte (number).
- Decodes each scanned digit back to BCD and reassembles the HH.MM.SS value as binary fields.
- Used as an on-board loopback/self-check monitor and as a bench scoreboard front-end.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is captured (1..15).
- TIMEOUT_CYCLES, 1_000_000: clk cycles with no new capture after which lock is dropped.

Ports:
- clk  in  1  system clock
- reset_mod  in  1  reset, asynchronous, active-low
- digit_block  in  6  active-low one-hot digit select; 6'b111111 = blank
- number  in  8  active-low segments; bit7 = dot, bits[6:0] = g..a
- hours  out  6  decoded hours, binary 0..23
- minutes  out  6  decoded minutes, binary 0..59
- seconds  out  6  decoded seconds, binary 0..59
- time_valid  out  1  one-cycle pulse when hours/minutes/seconds update
- frame_err  out  1  one-cycle pulse when a frame is discarded
- locked  out  1  high after a good frame; cleared by timeout or blank

Behaviour:
- Reset (reset_mod low, async): hours/minutes/seconds=0, time_valid=0, frame_err=0, locked=0, frame mask cleared, FSM=IDLE.
- Inputs pass through 2-flop synchronizers before any use.
- Digit slots (DIGIT_BLOCK_k has bit k-1 low):
  - slot0 = seconds ones
  - slot1 = seconds tens
  - slot2 = minutes ones, dot lit
  - slot3 = minutes tens
  - slot4 = hours ones, dot lit
  - slot5 = hours tens
- Segment codes (NUMBER_0..9): C0 F9 A4 B0 99 92 82 F8 80 90 (hex, bit7=1). Dot lit means bit7=0.
- FSM:
  - IDLE: on a change of the synced {digit_block,number} pair, go to SETTLE with count=1.
  - SETTLE: each cycle the pair is unchanged, count+1; any change restarts count=1. When count reaches SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE (1 cycle): process the sample, then go to HOLD.
  - HOLD: wait for the next pair change, then go to SETTLE.
- Capture latency: 2 (sync) + SETTLE_CYCLES + 1 clk after inputs become stable.
- CAPTURE rules:
  - digit_block == 6'b111111 (blank): clear frame mask and bad flag, locked<=0, no error pulse.
  - digit_block not one-hot-low: frame_err pulse, clear mask.
  - Otherwise decode number[6:0]. Unknown pattern, or dot state wrong for the slot, sets the frame bad flag.
  - Store the digit in its slot and set its mask bit. A recaptured slot overwrites the stored digit.
- Frame complete when mask == 6'b111111:
  - Good frame: bad flag clear, tens*10+ones gives seconds<60, minutes<60, hours<24.
  - Good frame registers the three outputs, pulses time_valid, sets locked.
  - Otherwise pulse frame_err; outputs unchanged.
  - In both cases mask and bad flag clear on the same cycle.
- Arithmetic: tens digit ×10 computed as (t<<3)+(t<<1), result 6 bits. Digits >5 in a seconds/minutes tens slot, or hours >23, count as range errors.
- Watchdog: counter reloads on every CAPTURE. Reaching TIMEOUT_CYCLES clears locked and the mask. Outputs hold their last good value.
- time_valid and frame_err are never asserted in the same cycle.
- Reset mid-frame discards all partial state immediately.

Decomposition:
- const.sv (shared):
  - NUMBER_0..9 and DIGIT_BLOCK_1..6 constants.
  - Slot index localparams and the dot-required mask 6'b010100.
- One sub-module, seg7_digit_decode (combinational): input 8-bit segment byte; outputs digit[3:0], pattern_ok, dot_lit.

Test Plan:
- Scan 12.34.56 with SETTLE_CYCLES+3 hold per digit -> hours=12, minutes=34, seconds=56, one time_valid pulse, locked=1.
- Slot2 sent as F9 with dot clear (unlit) -> frame_err pulse at frame end; outputs keep the previous 12/34/56.
- Seconds tens = 6 (82 on slot1) -> frame_err; no time_valid.
- digit_block=6'b111100 held stable -> frame_err pulse, mask cleared; the next clean frame 00.00.00 decodes to 0/0/0.
- Glitch: number toggles every 2 cycles with SETTLE_CYCLES=4 -> no capture; scan stops for TIMEOUT_CYCLES -> locked falls to 0.
- Assert reset_mod low after slot3 captured, release, send full 23.59.59 -> hours=23, minutes=59, seconds=59, exactly one time_valid pulse.
